// File: rtl/xm23_pic_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : xm23_pic_pkg
//  Purpose : Shared constants for the xm23 priority interrupt controller:
//            the FSM encoding, pic_in field positions and default device slots.
//  Rev     : 1.0  initial release
// ============================================================================
package xm23_pic_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] ACK  = 2'd2;

    localparam int IRQ_BIT  = 7;
    localparam int PRI_MSB  = 6;
    localparam int PRI_LSB  = 4;
    localparam int VECT_MSB = 3;
    localparam int VECT_LSB = 0;

    localparam int TMR = 0;
    localparam int KB  = 1;
    localparam int SCR = 2;
    localparam int TL  = 3;
    localparam int PB  = 4;

endpackage
`default_nettype wire

// File: rtl/xm23_pic_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : xm23_pic_arbiter
//  Purpose : Combinational winner select over pending requests: highest
//            priority wins, ties resolved toward the lowest index.
//  Rev     : 1.0  initial release
// ============================================================================
module xm23_pic_arbiter #(
    parameter int N_DEV = 5
) (
    input  logic [N_DEV-1:0]   i_pending,
    input  logic [3*N_DEV-1:0] i_dev_pri,
    output logic               o_win_valid,
    output logic [3:0]         o_win_idx,
    output logic [2:0]         o_win_pri
);

    // Strictly-greater replacement while scanning upward keeps the lowest index on ties.
    always_comb begin
        o_win_valid = 1'b0;
        o_win_idx   = 4'd0;
        o_win_pri   = 3'd0;
        for (int i = 0; i < N_DEV; i++) begin
            if (i_pending[i] && (!o_win_valid || (i_dev_pri[3*i +: 3] > o_win_pri))) begin
                o_win_valid = 1'b1;
                o_win_idx   = 4'(i);
                o_win_pri   = i_dev_pri[3*i +: 3];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/xm23_pic.sv
`default_nettype none
// ============================================================================
//  Module  : xm23_pic
//  Purpose : Priority interrupt controller feeding the xm23_cpu control unit
//            over pic_in. Optional status ports under XM23_PIC_STATUS_EN.
//  Rev     : 1.0  initial release
// ============================================================================
module xm23_pic
    import xm23_pic_pkg::*;
#(
    parameter int N_DEV    = 5,
    parameter int VEC_BASE = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_DEV-1:0]   dev_req,
    input  logic [N_DEV-1:0]   dev_ie,
    input  logic [3*N_DEV-1:0] dev_pri,
    input  logic [2:0]         cur_pri,
    input  logic               pic_read,
    output logic [7:0]         pic_in,
    output logic               irq_taken
`ifdef XM23_PIC_STATUS_EN
    ,
    output logic [N_DEV-1:0]   pic_pending,
    output logic               pic_busy
`endif
);

    localparam logic [3:0] c_vec_base = 4'(VEC_BASE);

    logic [N_DEV-1:0] r_req_d;
    logic [N_DEV-1:0] r_pending;
    logic [1:0]       r_state;
    logic [3:0]       r_gnt_idx;
    logic [7:0]       r_pic_in;
    logic             r_irq_taken;

    logic [N_DEV-1:0] w_pend_nxt;
    logic             w_ack;
    logic             w_gnt_live;
    logic             w_win_valid;
    logic [3:0]       w_win_idx;
    logic [2:0]       w_win_pri;
    logic [3:0]       w_vect;

    xm23_pic_arbiter #(
        .N_DEV (N_DEV)
    ) u_arbiter (
        .i_pending   (r_pending),
        .i_dev_pri   (dev_pri),
        .o_win_valid (w_win_valid),
        .o_win_idx   (w_win_idx),
        .o_win_pri   (w_win_pri)
    );

    assign w_vect = w_win_idx + c_vec_base;
    assign w_ack  = (r_state == REQ) && pic_read;

    // Set is applied last so a fresh edge survives a same-cycle clear.
    always_comb begin
        w_pend_nxt = r_pending;
        w_gnt_live = 1'b0;
        for (int i = 0; i < N_DEV; i++) begin
            if ((r_gnt_idx == 4'(i)) && r_pending[i])
                w_gnt_live = 1'b1;
            if (!dev_ie[i] || (w_ack && (r_gnt_idx == 4'(i))))
                w_pend_nxt[i] = 1'b0;
            if (dev_req[i] && !r_req_d[i] && dev_ie[i])
                w_pend_nxt[i] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_d     <= '0;
            r_pending   <= '0;
            r_state     <= IDLE;
            r_gnt_idx   <= 4'd0;
            r_pic_in    <= 8'h00;
            r_irq_taken <= 1'b0;
        end else begin
            r_req_d     <= dev_req;
            r_pending   <= w_pend_nxt;
            r_irq_taken <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_win_valid && (w_win_pri > cur_pri)) begin
                        r_gnt_idx <= w_win_idx;
                        r_pic_in  <= {1'b1, w_win_pri, w_vect};
                        r_state   <= REQ;
                    end
                end
                REQ: begin
                    if (pic_read) begin
                        r_pic_in    <= 8'h00;
                        r_irq_taken <= 1'b1;
                        r_state     <= ACK;
                    end else if (!w_gnt_live) begin
                        r_pic_in <= 8'h00;
                        r_state  <= IDLE;
                    end
                end
                ACK: begin
                    if (!pic_read)
                        r_state <= IDLE;
                end
                default: begin
                    r_pic_in <= 8'h00;
                    r_state  <= IDLE;
                end
            endcase
        end
    end

    assign pic_in    = r_pic_in;
    assign irq_taken = r_irq_taken;

`ifdef XM23_PIC_STATUS_EN
    assign pic_pending = r_pending;
    assign pic_busy    = (r_state != IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_xm23_pic.sv
`default_nettype none
// ============================================================================
//  Module  : tb_xm23_pic
//  Purpose : Self-checking bench for xm23_pic: directed vector table, corner
//            sequences and randomized traffic against a reference model.
//  Rev     : 1.0  initial release
// ============================================================================
module tb_xm23_pic;

    localparam int N = 5;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   dev_req;
    logic [N-1:0]   dev_ie;
    logic [3*N-1:0] dev_pri;
    logic [2:0]     cur_pri;
    logic           pic_read;
    logic [7:0]     pic_in;
    logic           irq_taken;
`ifdef XM23_PIC_STATUS_EN
    logic [N-1:0]   pic_pending;
    logic           pic_busy;
`endif

    int vectors = 0;
    int miscompares = 0;

    xm23_pic #(.N_DEV(N), .VEC_BASE(0)) dut (
        .clk       (clk),
        .rst       (rst),
        .dev_req   (dev_req),
        .dev_ie    (dev_ie),
        .dev_pri   (dev_pri),
        .cur_pri   (cur_pri),
        .pic_read  (pic_read),
        .pic_in    (pic_in),
        .irq_taken (irq_taken)
`ifdef XM23_PIC_STATUS_EN
        ,
        .pic_pending (pic_pending),
        .pic_busy    (pic_busy)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a set of pending devices, a "serving" device and a
    // "waiting for strobe release" flag.
    bit       m_pend [N];
    bit       m_prev [N];
    bit       m_serving = 1'b0;
    bit       m_release = 1'b0;
    int       m_gnt = 0;
    logic [7:0] m_pic = 8'h00;
    bit       m_taken = 1'b0;

    function automatic int pri_of(int i);
        return int'(dev_pri[3*i +: 3]);
    endfunction

    task automatic model_step();
        bit old_pend [N];
        int best;
        int winner;
        bit ack;
        int old_gnt;
        if (rst) begin
            for (int i = 0; i < N; i++) begin m_pend[i] = 0; m_prev[i] = 0; end
            m_serving = 0; m_release = 0; m_gnt = 0; m_pic = 8'h00; m_taken = 0;
            return;
        end
        old_pend = m_pend;
        old_gnt  = m_gnt;
        ack      = m_serving && pic_read;
        best     = -1;
        winner   = -1;
        for (int i = 0; i < N; i++) if (old_pend[i] && pri_of(i) > best) best = pri_of(i);
        for (int i = 0; i < N; i++) if (old_pend[i] && pri_of(i) == best && winner < 0) winner = i;
        m_taken = 0;
        if (m_serving) begin
            if (pic_read) begin
                m_pic = 8'h00; m_taken = 1; m_serving = 0; m_release = 1;
            end else if (!old_pend[m_gnt]) begin
                m_pic = 8'h00; m_serving = 0;
            end
        end else if (m_release) begin
            if (!pic_read) m_release = 0;
        end else if (winner >= 0 && best > int'(cur_pri)) begin
            m_gnt = winner;
            m_pic = {1'b1, 3'(best), 4'(winner)};
            m_serving = 1;
        end
        for (int i = 0; i < N; i++) begin
            bit keep;
            bit set;
            keep = old_pend[i] && dev_ie[i] && !(ack && i == old_gnt);
            set  = dev_req[i] && !m_prev[i] && dev_ie[i];
            m_pend[i] = keep || set;
            m_prev[i] = dev_req[i];
        end
    endtask

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("model_pic_in", 32'(pic_in), 32'(m_pic));
        check("model_irq_taken", 32'(irq_taken), 32'(m_taken));
`ifdef XM23_PIC_STATUS_EN
        begin
            logic [N-1:0] mp;
            for (int i = 0; i < N; i++) mp[i] = m_pend[i];
            check("model_pic_pending", 32'(pic_pending), 32'(mp));
            check("model_pic_busy", 32'(pic_busy), 32'(m_serving || m_release));
        end
`endif
    endtask

    typedef struct {
        logic           rst;
        logic [N-1:0]   req;
        logic [3*N-1:0] pri;
        logic [2:0]     cur;
        logic           rd;
        logic [7:0]     exp_pic;
        logic           exp_taken;
    } vec_t;

    vec_t tbl [$];

    task automatic add(logic r, logic [N-1:0] q, logic [3*N-1:0] p, logic [2:0] c,
                       logic rd, logic [7:0] ep, logic et);
        vec_t v;
        v.rst = r; v.req = q; v.pri = p; v.cur = c; v.rd = rd; v.exp_pic = ep; v.exp_taken = et;
        tbl.push_back(v);
    endtask

    initial begin
        int taken_cnt;
        rst = 1'b1; dev_req = '0; dev_ie = 5'h1F; dev_pri = '0; cur_pri = 3'd0; pic_read = 1'b0;

        // Single device: edge, grant two cycles later, acknowledge.
        add(1, 5'b00000, 15'h0003, 0, 0, 8'h00, 0);
        add(0, 5'b00000, 15'h0003, 0, 0, 8'h00, 0);
        add(0, 5'b00001, 15'h0003, 0, 0, 8'h00, 0);
        add(0, 5'b00001, 15'h0003, 0, 0, 8'hB0, 0);
        add(0, 5'b00001, 15'h0003, 0, 0, 8'hB0, 0);
        add(0, 5'b00001, 15'h0003, 0, 1, 8'h00, 1);
        add(0, 5'b00001, 15'h0003, 0, 0, 8'h00, 0);
        add(0, 5'b00001, 15'h0003, 0, 0, 8'h00, 0);
        // Tie between devices 1 and 4 at priority 5.
        add(0, 5'b10011, 15'h502B, 2, 0, 8'h00, 0);
        add(0, 5'b10011, 15'h502B, 2, 0, 8'hD1, 0);
        add(0, 5'b10011, 15'h502B, 2, 1, 8'h00, 1);
        add(0, 5'b10011, 15'h502B, 2, 0, 8'h00, 0);
        add(0, 5'b10011, 15'h502B, 2, 0, 8'hD4, 0);
        add(0, 5'b10011, 15'h502B, 2, 1, 8'h00, 1);
        add(0, 5'b10011, 15'h502B, 2, 0, 8'h00, 0);
        add(0, 5'b10011, 15'h502B, 2, 0, 8'h00, 0);
        // Equal priority is held until the CPU priority drops.
        add(0, 5'b10111, 15'h50AB, 2, 0, 8'h00, 0);
        add(0, 5'b10111, 15'h50AB, 2, 0, 8'h00, 0);
        add(0, 5'b10111, 15'h50AB, 2, 0, 8'h00, 0);
        add(0, 5'b10111, 15'h50AB, 1, 0, 8'hA2, 0);
        add(0, 5'b10111, 15'h50AB, 1, 1, 8'h00, 1);
        add(0, 5'b10111, 15'h50AB, 1, 0, 8'h00, 0);

        foreach (tbl[k]) begin
            rst = tbl[k].rst; dev_req = tbl[k].req; dev_pri = tbl[k].pri;
            cur_pri = tbl[k].cur; pic_read = tbl[k].rd;
            tick();
            check($sformatf("tbl%0d_pic_in", k), 32'(pic_in), 32'(tbl[k].exp_pic));
            check($sformatf("tbl%0d_irq_taken", k), 32'(irq_taken), 32'(tbl[k].exp_taken));
        end

        // Held strobe: one pulse only, next grant waits for release.
        cur_pri = 3'd0; dev_req = 5'b00000; tick();
        dev_pri = 15'h52AB; dev_req = 5'b01001; tick();
        tick();
        check("held_first_grant", 32'(pic_in), 32'hB0);
`ifdef XM23_PIC_STATUS_EN
        check("status_pending", 32'(pic_pending), 32'b01001);
        check("status_busy", 32'(pic_busy), 32'd1);
`endif
        pic_read = 1'b1;
        taken_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (irq_taken) taken_cnt++;
            check("held_pic_in_low", 32'(pic_in), 32'h00);
        end
        check("held_taken_count", 32'(taken_cnt), 32'd1);
        pic_read = 1'b0; tick();
        check("held_release_idle", 32'(pic_in), 32'h00);
        tick();
        check("held_next_grant", 32'(pic_in), 32'h93);
        pic_read = 1'b1; tick();
        pic_read = 1'b0; tick();

        // Enable withdrawn while requesting.
        dev_req = 5'b00000; tick();
        dev_req = 5'b00100; tick();
        tick();
        check("withdraw_grant", 32'(pic_in), 32'hA2);
        dev_ie = 5'b11011; tick();
        tick();
        check("withdraw_pic_in", 32'(pic_in), 32'h00);
        check("withdraw_taken", 32'(irq_taken), 32'd0);
        dev_ie = 5'h1F;

        // Reset in the middle of a request.
        dev_req = 5'b00000; tick();
        dev_req = 5'b00100; tick();
        tick();
        check("rst_pre_grant", 32'(pic_in), 32'hA2);
        rst = 1'b1; tick();
        check("rst_pic_in", 32'(pic_in), 32'h00);
        check("rst_taken", 32'(irq_taken), 32'd0);
        rst = 1'b0;

        // Randomized traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 3) == 0) dev_req = N'($urandom);
            dev_ie   = ($urandom_range(0, 15) == 0) ? N'($urandom) : 5'h1F;
            if ($urandom_range(0, 49) == 0) dev_pri = (3*N)'($urandom);
            if ($urandom_range(0, 7) == 0) cur_pri = 3'($urandom);
            pic_read = ($urandom_range(0, 2) == 0);
            rst      = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/xm23_pic.md
Name: xm23_pic

Overview:
- Priority interrupt controller sitting directly upstream of the xm23_cpu control unit.
- Latches device interrupt requests (timer, keyboard, screen, traffic lights, pedestrian button) and arbitrates them by priority.
- Presents one request (valid, priority, vector number) on the 8-bit pic_in bus, which replaces the constant tie-off.
- Retires that request when the control unit pulses pic_read.

Parameters:
- N_DEV, 5, number of device request inputs (index 0..N_DEV-1, maximum 16).
- VEC_BASE, 0, vector number of device 0; device i uses vector VEC_BASE+i, truncated to 4 bits.

Ports:
- Clock  input  1  system clock; all state updates on posedge.
- Reset  input  1  synchronous, active-high reset.
- dev_req  input  N_DEV  device request levels (DBA/OF-derived) from the device drivers.
- dev_ie  input  N_DEV  per-device interrupt enable (CSR bit 0).
- dev_pri  input  3*N_DEV  per-device priority; bits [3i+2:3i] belong to device i.
- cur_pri  input  3  current CPU priority, PSW[7:5].
- pic_read  input  1  acknowledge strobe from the control unit.
- pic_in  output  8  {irq, pri[2:0], vect[3:0]}, sent to the control unit.
- irq_taken  output  1  one-cycle pulse when a request is acknowledged.

Behaviour:
- Reset values: pending, req_d and all outputs are 0; state is IDLE. Reset takes priority over every other event, including a reset during REQ or ACK.
- Edge detect: req_d <= dev_req every cycle. pending[i] is set when dev_req[i] & ~req_d[i] & dev_ie[i].
- pending clear:
  - Cleared when dev_ie[i] is 0.
  - Cleared for the granted device on acknowledge.
  - Set and clear in the same cycle for the same bit: set wins, so a new edge is not lost.
- Arbitration (combinational, over pending):
  - Winner is the highest dev_pri. Ties go to the lowest index.
  - Eligible only if winner pri > cur_pri (strict). Equal or lower priority is held pending.
- FSM states IDLE, REQ, ACK:
  - IDLE: if an eligible winner exists, latch gnt_idx, gnt_pri and gnt_vect, then go to REQ. pic_in is driven from the latched values starting the next cycle.
  - REQ: irq=1 and pic_in is stable; the grant is never re-arbitrated mid-request.
    - pic_read=1: clear pending[gnt_idx], pulse irq_taken, irq=0, go to ACK.
    - Granted pending bit drops before pic_read (IE cleared): drop irq and return to IDLE (request withdrawn).
  - ACK: wait for pic_read=0, then go to IDLE. This prevents a held strobe from acknowledging twice.
- Latency: a dev_req rising edge at cycle t sets pending at t+1. irq is visible at t+2 if the device is eligible.
- A cur_pri rise above gnt_pri while in REQ does not cancel the request; the control unit resolves that case.
- pic_in is 8'h00 whenever irq=0.
- With no eligible requests the FSM stays in IDLE indefinitely. Multiple pending requests are served one per REQ/ACK cycle, minimum 3 cycles apart.

Optional Feature:
- Macro XM23_PIC_STATUS_EN.
- When defined:
  - Adds output pic_pending [N_DEV-1:0], which mirrors the pending register and resets to 0.
  - Adds output pic_busy, which is 1 when state != IDLE.
- When undefined: neither port exists, and the logic is otherwise identical.

Decomposition:
- Package xm23_pic_pkg holds:
  - the state encoding (IDLE=2'd0, REQ=2'd1, ACK=2'd2);
  - pic_in field positions: IRQ_BIT=7, PRI_MSB=6, PRI_LSB=4, VECT_MSB=3, VECT_LSB=0;
  - the default device indices TMR=0, KB=1, SCR=2, TL=3, PB=4.
- Sub-module xm23_pic_arbiter: combinational priority/tie-break selector producing the winner index, winner priority and valid.

Test Plan:
- Reset, then an edge on dev_req[0] (ie=1, pri=3, cur_pri=0): pic_in=8'hB0 two cycles after the edge. Pulse pic_read: irq_taken=1 for 1 cycle, pic_in=0, pending[0]=0.
- Simultaneous edges on devices 1 (pri 5) and 4 (pri 5), cur_pri=2: device 1 is granted first (pic_in=8'hD1). After acknowledge and pic_read low, device 4 is granted (8'hD4).
- Device 2 pri=2 with cur_pri=2: no irq, pending stays set. Set cur_pri=1: pic_in=8'hA2 within 1 cycle of the change plus the FSM cycle.
- pic_read held high for 5 cycles: exactly one irq_taken pulse. The next pending request is not granted until pic_read returns low.
- In REQ, deassert dev_ie for the granted device: irq drops and the FSM returns to IDLE with no irq_taken. Assert Reset during REQ: all outputs are 0 the next cycle.
- With XM23_PIC_STATUS_EN, edges on devices 0 and 3 with ie=1: pic_pending=5'b01001 and pic_busy=1 while in REQ.
